// File: rtl/bitonic_sort4_stream_pkg.sv
// Shared types and constants for the 4-element bitonic sort stream.
package sort_pkg;

  localparam int SORT_N = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    EMIT    = 2'd2
  } state_e;

  typedef logic [1:0] idx_t;

endpackage

// File: rtl/bitonic_sort4_stream_if.sv
// Producer/consumer stream bundle around the bitonic sorter.
interface bitonic_sort4_stream_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bitonic_sort4_stream_cmp_swap.sv
// Unsigned compare-exchange cell: dir=1 puts the smaller value on lo,
// dir=0 puts the larger value on lo. Equal inputs pass straight through.
module sort_cmp_swap #(
  parameter int W = 8
) (
  input  logic         dir,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swap;

  // Strict compares keep equal pairs in place.
  always_comb begin
    swap = dir ? (a > b) : (a < b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/bitonic_sort4_stream.sv
// Collects four elements, sorts them with a 3-stage bitonic network
// (one stage per clock), then streams them out one per handshake.
module bitonic_sort4_stream
  import sort_pkg::*;
#(
  parameter int W         = 8,
  parameter bit ASCENDING = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  bitonic_sort4_stream_if.slave s
);
  state_e       state_q, state_d;
  idx_t         cnt_q, cnt_d, stage_q, stage_d, idx_q, idx_d, out_sel;
  logic [W-1:0] b_q [SORT_N];
  logic [W-1:0] b_d [SORT_N];
  logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d, busy_q, busy_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         cs0_dir, cs1_dir;
  logic [W-1:0] cs0_a, cs0_b, cs0_lo, cs0_hi, cs1_a, cs1_b, cs1_lo, cs1_hi;

  sort_cmp_swap #(.W(W)) u_cs0 (.dir(cs0_dir), .a(cs0_a), .b(cs0_b), .lo(cs0_lo), .hi(cs0_hi));
  sort_cmp_swap #(.W(W)) u_cs1 (.dir(cs1_dir), .a(cs1_a), .b(cs1_b), .lo(cs1_lo), .hi(cs1_hi));

  // Stage 0 builds the bitonic sequence; stage 1 pairs across halves.
  always_comb begin
    cs0_a   = b_q[0];
    cs0_b   = b_q[1];
    cs0_dir = 1'b1;
    cs1_a   = b_q[2];
    cs1_b   = b_q[3];
    cs1_dir = 1'b1;
    case (stage_q)
      2'd0: cs1_dir = 1'b0;
      2'd1: begin
        cs0_b = b_q[2];
        cs1_a = b_q[1];
      end
      default: begin
        cs1_dir = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    b_d     = b_q;
    case (state_q)
      COLLECT: begin
        if (s.in_valid && in_ready_q) begin
          b_d[cnt_q] = s.in_data;
          cnt_d      = idx_t'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) begin
            state_d = SORT;
            stage_d = 2'd0;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      SORT: begin
        if (stage_q == 2'd1) begin
          b_d[0] = cs0_lo;
          b_d[2] = cs0_hi;
          b_d[1] = cs1_lo;
          b_d[3] = cs1_hi;
        end else begin
          b_d[0] = cs0_lo;
          b_d[1] = cs0_hi;
          b_d[2] = cs1_lo;
          b_d[3] = cs1_hi;
        end
        if (stage_q == 2'd2) begin
          state_d = EMIT;
          stage_d = 2'd0;
          idx_d   = 2'd0;
        end else begin
          stage_d = idx_t'(stage_q + 2'd1);
        end
      end
      EMIT: begin
        if (out_valid_q && s.out_ready) begin
          idx_d = idx_t'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            state_d = COLLECT;
          end else begin
            state_d = EMIT;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = 2'd0;
        stage_d = 2'd0;
        idx_d   = 2'd0;
      end
    endcase

    // Outputs are registered from next-state values so they align with state.
    out_sel     = ASCENDING ? idx_d : idx_t'(2'd3 - idx_d);
    in_ready_d  = (state_d == COLLECT);
    busy_d      = (state_d != COLLECT);
    out_valid_d = (state_d == EMIT);
    out_last_d  = (state_d == EMIT) && (idx_d == 2'd3);
    out_data_d  = (state_d == EMIT) ? b_d[out_sel] : '0;
  end

  // State, buffer and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= 2'd0;
      stage_q     <= 2'd0;
      idx_q       <= 2'd0;
      for (int i = 0; i < SORT_N; i++) b_q[i] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      idx_q       <= idx_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign s.busy      = busy_q;
endmodule

// File: tb/tb_bitonic_sort4_stream.sv
// Scoreboard bench: three sorter instances (W=8 asc, W=8 desc, W=1 asc).
module tb_bitonic_sort4_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;
  int t_acc = 0;
  logic [7:0] exp_q[$];

  logic [2:0]      in_valid_v = 3'd0;
  logic [2:0]      out_ready_v = 3'd0;
  logic [2:0][7:0] in_data_v = '0;

  bitonic_sort4_stream_if #(.W(8)) if_a ();
  bitonic_sort4_stream_if #(.W(8)) if_d ();
  bitonic_sort4_stream_if #(.W(1)) if_b ();

  assign if_a.in_valid  = in_valid_v[0];
  assign if_a.in_data   = in_data_v[0];
  assign if_a.out_ready = out_ready_v[0];
  assign if_d.in_valid  = in_valid_v[1];
  assign if_d.in_data   = in_data_v[1];
  assign if_d.out_ready = out_ready_v[1];
  assign if_b.in_valid  = in_valid_v[2];
  assign if_b.in_data   = in_data_v[2][0];
  assign if_b.out_ready = out_ready_v[2];

  wire [2:0]      ov_w = {if_b.out_valid, if_d.out_valid, if_a.out_valid};
  wire [2:0]      ir_w = {if_b.in_ready, if_d.in_ready, if_a.in_ready};
  wire [2:0]      ol_w = {if_b.out_last, if_d.out_last, if_a.out_last};
  wire [2:0]      bz_w = {if_b.busy, if_d.busy, if_a.busy};
  wire [2:0][7:0] od_w = {{7'd0, if_b.out_data}, if_d.out_data, if_a.out_data};

  bitonic_sort4_stream #(.W(8), .ASCENDING(1'b1)) u_asc  (.clk(clk), .rst_n(rst_n), .s(if_a));
  bitonic_sort4_stream #(.W(8), .ASCENDING(1'b0)) u_desc (.clk(clk), .rst_n(rst_n), .s(if_d));
  bitonic_sort4_stream #(.W(1), .ASCENDING(1'b1)) u_bit  (.clk(clk), .rst_n(rst_n), .s(if_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int d);
    check("idle_in_ready", 32'(ir_w[d]), 32'd1);
    check("idle_out_valid", 32'(ov_w[d]), 32'd0);
    check("idle_out_data", 32'(od_w[d]), 32'd0);
    check("idle_out_last", 32'(ol_w[d]), 32'd0);
    check("idle_busy", 32'(bz_w[d]), 32'd0);
  endtask

  // Drive one group and push its reference ordering onto the scoreboard.
  task automatic send(input int d, input logic [7:0] v0, input logic [7:0] v1,
                      input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] v[4];
    logic [7:0] srt[4];
    logic [7:0] tmp;
    v = '{v0, v1, v2, v3};
    srt = v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
    for (int i = 0; i < 4; i++) exp_q.push_back((d == 1) ? srt[3-i] : srt[i]);
    for (int k = 0; k < 4; k++) begin
      in_valid_v[d] = 1'b1;
      in_data_v[d] = v[k];
      check("in_ready_collect", 32'(ir_w[d]), 32'd1);
      @(posedge clk); #1;
    end
    in_valid_v[d] = 1'b0;
    in_data_v[d] = 8'd0;
    t_acc = cyc;
  endtask

  // Pull one group; optional 5-cycle stall after the first element.
  task automatic recv(input int d, input bit stall);
    int t;
    logic [7:0] e;
    out_ready_v[d] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!ov_w[d] && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      check("out_valid", 32'(ov_w[d]), 32'd1);
      if (k == 0) check("latency", 32'(cyc - t_acc), 32'd3);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("out_data", 32'(od_w[d]), 32'(e));
      check("out_last", 32'(ol_w[d]), (k == 3) ? 32'd1 : 32'd0);
      check("in_ready_busy", 32'(ir_w[d]), 32'd0);
      check("busy", 32'(bz_w[d]), 32'd1);
      if (stall && k == 0) begin
        out_ready_v[d] = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_valid", 32'(ov_w[d]), 32'd1);
          check("hold_data", 32'(od_w[d]), 32'(e));
          check("hold_in_ready", 32'(ir_w[d]), 32'd0);
        end
        out_ready_v[d] = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid_v[d] = 1'b0;
    out_ready_v[d] = 1'b0;
    check_idle(d);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_idle(d);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 8'd3, 8'd1, 8'd4, 8'd2);
    recv(0, 1'b0);

    send(1, 8'd7, 8'd7, 8'd0, 8'd255);
    recv(1, 1'b0);

    // Stray in_valid during SORT/EMIT must not be captured.
    send(0, 8'd3, 8'd1, 8'd4, 8'd2);
    in_valid_v[0] = 1'b1;
    in_data_v[0] = 8'hEE;
    recv(0, 1'b1);
    in_data_v[0] = 8'd0;

    send(0, 8'd5, 8'd5, 8'd5, 8'd5);
    recv(0, 1'b0);

    send(2, 8'd1, 8'd0, 8'd1, 8'd1);
    recv(2, 1'b0);
    send(2, 8'd0, 8'd0, 8'd1, 8'd0);
    recv(2, 1'b0);

    repeat (3) begin
      send(0, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
              8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      recv(0, 1'b0);
      send(1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
              8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      recv(1, 1'b0);
    end

    // Abort a group during stage 1; nothing of it may appear.
    send(0, 8'd10, 8'd20, 8'd30, 8'd40);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle(0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_partial_out", 32'(ov_w[0]), 32'd0);
    end

    send(0, 8'd9, 8'd8, 8'd7, 8'd6);
    recv(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
